// File: rtl/ttl_pkg.sv
// Shared constants, payload types and helpers for the clocked 74xx gate bank.
package ttl_pkg;

  typedef enum logic {
    TTL_TOTEM          = 1'b0,
    TTL_OPEN_COLLECTOR = 1'b1
  } ttl_mode_e;

  localparam int unsigned CHANNELS_MIN = 1;
  localparam int unsigned CHANNELS_MAX = 32;
  localparam int unsigned FILTER_MIN   = 1;
  localparam int unsigned FILTER_MAX   = 255;
  localparam int unsigned DELAY_MIN    = 0;
  localparam int unsigned DELAY_MAX    = 8;

  // Per-channel result handed from a filter channel to the bank.
  typedef struct packed {
    logic level;
    logic pulse;
  } ttl_chan_t;

  // Counter must hold 0..FILTER-1; one extra code keeps FILTER=1 at one bit.
  function automatic int unsigned cnt_width(int unsigned filter);
    return $clog2(filter + 1);
  endfunction

endpackage

// File: rtl/ttl_7414_bank_if.sv
// Channel bus of the gate bank: raw inputs in, levels, driver enables and change pulses out.
interface ttl_7414_bank_if #(
  parameter int unsigned CHANNELS = 6
);

  logic [CHANNELS-1:0] a;
  logic [CHANNELS-1:0] y;
  logic [CHANNELS-1:0] y_oe;
  // One-cycle pulse per channel when its filtered level changes.
  logic [CHANNELS-1:0] level_edge;

  modport master (
    output a,
    input  y,
    input  y_oe,
    input  level_edge
  );

  modport slave (
    input  a,
    output y,
    output y_oe,
    output level_edge
  );

endinterface

// File: rtl/ttl_schmitt_channel.sv
// One gate channel: input capture + 2-flop synchroniser, hysteresis filter, optional inversion, delay pipe.
module ttl_schmitt_channel
  import ttl_pkg::*;
#(
  parameter int unsigned INVERT = 1,
  parameter int unsigned FILTER = 4,
  parameter int unsigned DELAY  = 1
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      a,
  output ttl_chan_t out
);

  localparam int unsigned    CW       = cnt_width(FILTER);
  localparam logic [CW-1:0]  CNT_LAST = CW'(FILTER - 1);
  localparam logic           INV      = (INVERT != 0);

  logic          a_q;
  logic          sync1;
  logic          a_sync;
  logic          s;
  logic          s_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          flip_c;
  logic          pulse;
  logic          level_c;
  logic          level;

  // Pad capture register followed by the two metastability flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= 1'b0;
      sync1  <= 1'b0;
      a_sync <= 1'b0;
    end else begin
      a_q    <= a;
      sync1  <= a_q;
      a_sync <= sync1;
    end
  end

  // Any agreement with the held level restarts the count, so short pulses never flip it.
  always_comb begin
    flip_c  = 1'b0;
    s_nxt   = s;
    cnt_nxt = '0;
    if (a_sync != s) begin
      if (cnt == CNT_LAST) begin
        flip_c = 1'b1;
        s_nxt  = ~s;
      end else begin
        cnt_nxt = cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s     <= 1'b0;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      s     <= s_nxt;
      cnt   <= cnt_nxt;
      pulse <= flip_c;
    end
  end

  assign level_c = s ^ INV;

  generate
    if (DELAY == 0) begin : g_no_delay
      assign level = level_c;
    end else begin : g_delay
      logic [DELAY-1:0] pipe;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pipe <= {DELAY{INV}};
        end else begin
          pipe[0] <= level_c;
          for (int k = 1; k < DELAY; k++) begin
            pipe[k] <= pipe[k-1];
          end
        end
      end

      assign level = pipe[DELAY-1];
    end
  endgenerate

  assign out = ttl_chan_t'{level: level, pulse: pulse};

endmodule

// File: rtl/ttl_7414_bank.sv
// Clocked 7414/7404/7407-style gate bank: CHANNELS independent filtered channels with totem or OC drive.
module ttl_7414_bank
  import ttl_pkg::*;
#(
  parameter int unsigned CHANNELS       = 6,
  parameter int unsigned INVERT         = 1,
  parameter int unsigned OPEN_COLLECTOR = 0,
  parameter int unsigned FILTER         = 4,
  parameter int unsigned DELAY          = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  ttl_7414_bank_if.slave    bus
);

  localparam ttl_mode_e MODE = (OPEN_COLLECTOR != 0) ? TTL_OPEN_COLLECTOR : TTL_TOTEM;

  generate
    if (CHANNELS < CHANNELS_MIN || CHANNELS > CHANNELS_MAX) begin : g_bad_channels
      $fatal(1, "ttl_7414_bank: CHANNELS out of range");
    end
    if (FILTER < FILTER_MIN || FILTER > FILTER_MAX) begin : g_bad_filter
      $fatal(1, "ttl_7414_bank: FILTER out of range");
    end
    if (DELAY > DELAY_MAX) begin : g_bad_delay
      $fatal(1, "ttl_7414_bank: DELAY out of range");
    end
    if (INVERT > 1) begin : g_bad_invert
      $fatal(1, "ttl_7414_bank: INVERT must be 0 or 1");
    end
    if (OPEN_COLLECTOR > 1) begin : g_bad_oc
      $fatal(1, "ttl_7414_bank: OPEN_COLLECTOR must be 0 or 1");
    end
  endgenerate

  ttl_chan_t           ch_out [CHANNELS];
  logic [CHANNELS-1:0] level;
  logic [CHANNELS-1:0] pulse;

  generate
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      ttl_schmitt_channel #(
        .INVERT (INVERT),
        .FILTER (FILTER),
        .DELAY  (DELAY)
      ) u_ch (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (bus.a[i]),
        .out   (ch_out[i])
      );
    end
  endgenerate

  always_comb begin
    level = '0;
    pulse = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      level[i] = ch_out[i].level;
      pulse[i] = ch_out[i].pulse;
    end
  end

  assign bus.y          = level;
  assign bus.level_edge = pulse;

  // Open collector only sinks current: the driver is enabled while pulling low.
  generate
    if (MODE == TTL_OPEN_COLLECTOR) begin : g_oc
      assign bus.y_oe = ~level;
    end else begin : g_totem
      assign bus.y_oe = '1;
    end
  endgenerate

endmodule

// File: tb/tb_ttl_7414_bank.sv
// Bench for ttl_7414_bank: an inverting totem bank and a buffering OC bank against a sliding-window model.
module tb_ttl_7414_bank;

  localparam int unsigned N  = 6;
  localparam int unsigned F0 = 4;
  localparam int unsigned D0 = 1;
  localparam int unsigned F1 = 2;
  localparam int unsigned D1 = 0;
  localparam int FILT [2] = '{F0, F1};
  localparam int DLY  [2] = '{D0, D1};
  localparam int INV  [2] = '{1, 0};
  localparam int OC   [2] = '{0, 1};
  localparam int LAT0 = 2 + F0 + D0;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  ttl_7414_bank_if #(.CHANNELS(N)) if0 ();
  ttl_7414_bank_if #(.CHANNELS(N)) if1 ();

  ttl_7414_bank #(
    .CHANNELS(N), .INVERT(1), .OPEN_COLLECTOR(0), .FILTER(F0), .DELAY(D0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0)
  );

  ttl_7414_bank #(
    .CHANNELS(N), .INVERT(0), .OPEN_COLLECTOR(1), .FILTER(F1), .DELAY(D1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0] act_y  [2];
  logic [N-1:0] act_oe [2];
  logic [N-1:0] act_ev [2];
  assign act_y[0]  = if0.y;
  assign act_y[1]  = if1.y;
  assign act_oe[0] = if0.y_oe;
  assign act_oe[1] = if1.y_oe;
  assign act_ev[0] = if0.level_edge;
  assign act_ev[1] = if1.level_edge;

  // Model: raw-input history, window of synchronised samples, history of held levels.
  logic [N-1:0] m_ah [2][3];
  logic [N-1:0] m_w  [2][8];
  logic [N-1:0] m_s  [2][9];
  logic [N-1:0] m_ev [2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        for (int k = 0; k < 3; k++) m_ah[d][k] = '0;
        for (int k = 0; k < 8; k++) m_w[d][k] = '0;
        for (int k = 0; k < 9; k++) m_s[d][k] = '0;
        m_ev[d] = '0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        logic [N-1:0] flip;
        for (int k = 7; k > 0; k--) m_w[d][k] = m_w[d][k-1];
        m_w[d][0] = m_ah[d][2];
        // A level flips only when the last FILTER samples all disagree with it.
        flip = '1;
        for (int k = 0; k < 8; k++) begin
          if (k < FILT[d]) flip = flip & (m_w[d][k] ^ m_s[d][0]);
        end
        m_ev[d] = flip;
        for (int k = 8; k > 0; k--) m_s[d][k] = m_s[d][k-1];
        m_s[d][0] = m_s[d][1] ^ flip;
        m_ah[d][2] = m_ah[d][1];
        m_ah[d][1] = m_ah[d][0];
        m_ah[d][0] = (d == 0) ? if0.a : if1.a;
      end
    end
  end

  function automatic logic [N-1:0] exp_y(int d);
    return m_s[d][DLY[d]] ^ ((INV[d] != 0) ? {N{1'b1}} : {N{1'b0}});
  endfunction

  function automatic logic [N-1:0] exp_oe(int d);
    logic [N-1:0] yv;
    yv = exp_y(d);
    return (OC[d] != 0) ? ~yv : {N{1'b1}};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    if0.a = '0;
    if1.a = '0;
    repeat (3) @(negedge clk);
    if (if0.y !== 6'b111111) begin errors++; $display("FAIL reset_init y0 got %b want 111111", if0.y); end
    checks++;
    if (if1.y !== 6'b000000) begin errors++; $display("FAIL reset_init y1 got %b want 000000", if1.y); end
    checks++;
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if0.a = N'($urandom);
      if1.a = N'($urandom);
    end
    // Asynchronous assert between clock edges, checked before any further edge.
    #2 rst_n = 1'b0;
    #1;
    if (if0.y !== 6'b111111) begin errors++; $display("FAIL reset_async y0 got %b want 111111", if0.y); end
    checks++;
    if (if0.y_oe !== 6'b111111) begin errors++; $display("FAIL reset_async oe0 got %b want 111111", if0.y_oe); end
    checks++;
    if (if0.level_edge !== 6'b000000) begin errors++; $display("FAIL reset_async edge0 got %b want 000000", if0.level_edge); end
    checks++;
    if (if1.y !== 6'b000000) begin errors++; $display("FAIL reset_async y1 got %b want 000000", if1.y); end
    checks++;
    if (if1.y_oe !== 6'b111111) begin errors++; $display("FAIL reset_async oe1 got %b want 111111", if1.y_oe); end
    checks++;
    if (if1.level_edge !== 6'b000000) begin errors++; $display("FAIL reset_async edge1 got %b want 000000", if1.level_edge); end
    checks++;
    if0.a = '0;
    if1.a = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    if (if0.y !== 6'b111111) begin errors++; $display("FAIL reset_release y0 got %b want 111111", if0.y); end
    checks++;
  endtask

  task automatic test_clean_edge();
    @(negedge clk);
    if0.a[0] = 1'b1;
    for (int e = 0; e <= 9; e++) begin
      logic exp_ev0;
      logic exp_y0;
      @(negedge clk);
      exp_ev0 = (e == 2 + int'(F0));
      exp_y0  = (e >= LAT0) ? 1'b0 : 1'b1;
      if (if0.level_edge[0] !== exp_ev0) begin
        errors++; $display("FAIL clean_edge edge0 after_edge=%0d got %b want %b", e, if0.level_edge[0], exp_ev0);
      end
      checks++;
      if (if0.y[0] !== exp_y0) begin
        errors++; $display("FAIL clean_edge y0 after_edge=%0d got %b want %b", e, if0.y[0], exp_y0);
      end
      checks++;
    end
    if0.a[0] = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_glitch();
    int falls;
    int pulses;
    logic prev;
    @(negedge clk);
    if0.a[2] = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (if0.y[2] !== 1'b1 || if0.level_edge[2] !== 1'b0) begin
        errors++; $display("FAIL glitch3 c=%0d y2/edge2 got %b%b want 10", c, if0.y[2], if0.level_edge[2]);
      end
      checks++;
      if (c == int'(F0) - 1) if0.a[2] = 1'b0;
    end
    falls  = 0;
    pulses = 0;
    prev   = if0.y[2];
    if0.a[2] = 1'b1;
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      if (prev === 1'b1 && if0.y[2] === 1'b0) falls++;
      if (if0.level_edge[2] === 1'b1) pulses++;
      prev = if0.y[2];
      if (c == int'(F0)) if0.a[2] = 1'b0;
    end
    if (falls !== 1) begin errors++; $display("FAIL glitch4 y2 falls got %0d want 1", falls); end
    checks++;
    if (pulses !== 2) begin errors++; $display("FAIL glitch4 edge2 pulses got %0d want 2", pulses); end
    checks++;
    if (if0.y[2] !== 1'b1) begin errors++; $display("FAIL glitch4 y2 final got %b want 1", if0.y[2]); end
    checks++;
  endtask

  task automatic test_buffer_oc();
    if1.a = 6'b000000;
    repeat (8) @(negedge clk);
    if (if1.y !== 6'b000000) begin errors++; $display("FAIL oc_low y got %b want 000000", if1.y); end
    checks++;
    if (if1.y_oe !== 6'b111111) begin errors++; $display("FAIL oc_low oe got %b want 111111", if1.y_oe); end
    checks++;
    if1.a = 6'b111111;
    for (int e = 0; e <= 6; e++) begin
      logic [N-1:0] wy;
      logic [N-1:0] we;
      @(negedge clk);
      wy = (e >= 2 + int'(F1) + int'(D1)) ? 6'b111111 : 6'b000000;
      we = (e == 2 + int'(F1)) ? 6'b111111 : 6'b000000;
      if (if1.y !== wy) begin errors++; $display("FAIL oc_rise y after_edge=%0d got %b want %b", e, if1.y, wy); end
      checks++;
      if (if1.y_oe !== ~wy) begin errors++; $display("FAIL oc_rise oe after_edge=%0d got %b want %b", e, if1.y_oe, ~wy); end
      checks++;
      if (if1.level_edge !== we) begin errors++; $display("FAIL oc_rise edge after_edge=%0d got %b want %b", e, if1.level_edge, we); end
      checks++;
    end
    if1.a = 6'b000000;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_independence();
    for (int p = 0; p < 4; p++) begin
      logic [N-1:0] a_old;
      logic [N-1:0] a_new;
      int ch;
      ch = (p % 2 == 0) ? 1 : 4;
      @(negedge clk);
      a_old = if0.a;
      a_new = a_old ^ N'(1 << ch);
      if0.a = a_new;
      for (int e = 0; e < 10; e++) begin
        logic [N-1:0] wy;
        logic [N-1:0] we;
        @(negedge clk);
        wy = ~((e >= LAT0) ? a_new : a_old);
        we = (e == 2 + int'(F0)) ? (a_new ^ a_old) : '0;
        if (if0.y !== wy) begin errors++; $display("FAIL indep p=%0d after_edge=%0d y got %b want %b", p, e, if0.y, wy); end
        checks++;
        if (if0.level_edge !== we) begin errors++; $display("FAIL indep p=%0d after_edge=%0d edge got %b want %b", p, e, if0.level_edge, we); end
        checks++;
      end
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_chatter();
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (if1.level_edge[5] !== 1'b0 || if1.y[5] !== 1'b0) begin
        errors++; $display("FAIL chatter c=%0d edge5/y5 got %b%b want 00", c, if1.level_edge[5], if1.y[5]);
      end
      checks++;
      if1.a[5] = ~if1.a[5];
    end
    if1.a[5] = 1'b0;
    repeat (6) @(negedge clk);
    if (if1.y[5] !== 1'b0) begin errors++; $display("FAIL chatter_after y5 got %b want 0", if1.y[5]); end
    checks++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (act_y[d] !== exp_y(d)) begin
          errors++; $display("FAIL random d=%0d c=%0d y got %b want %b", d, c, act_y[d], exp_y(d));
        end
        checks++;
        if (act_oe[d] !== exp_oe(d)) begin
          errors++; $display("FAIL random d=%0d c=%0d oe got %b want %b", d, c, act_oe[d], exp_oe(d));
        end
        checks++;
        if (act_ev[d] !== m_ev[d]) begin
          errors++; $display("FAIL random d=%0d c=%0d edge got %b want %b", d, c, act_ev[d], m_ev[d]);
        end
        checks++;
      end
      // Sparse toggles give a mix of accepted edges and rejected short pulses.
      if0.a = if0.a ^ N'($urandom & $urandom & $urandom);
      if1.a = if1.a ^ N'($urandom & $urandom);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    if0.a  = '0;
    if1.a  = '0;
    test_reset();
    test_clean_edge();
    test_glitch();
    test_buffer_oc();
    test_independence();
    test_chatter();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
